// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared constants and helper functions for the N-port dispatcher
package dispatch_pkg;

  localparam int STATS_W = 16;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Route field of a word: everything above the payload bits.
  function automatic logic [31:0] route_of(input logic [31:0] word, input int main_size);
    return word >> main_size;
  endfunction

endpackage

// File: rtl/pcie_dispatch_n_if.sv
// rtl/pcie_dispatch_n_if.sv - ingress/egress handshake bundle of the N-port dispatcher
interface pcie_dispatch_n_if #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int NUM_PORTS = 4
);

  logic [DATA_SIZE-1:0]           in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_PORTS*MAIN_SIZE-1:0] out_data;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0]           out_ready;
  logic [NUM_PORTS-1:0]           fifo_full;
  logic                           error_route;

  // Upstream producer and downstream consumers as seen from outside.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, fifo_full, error_route
  );

  // The dispatcher itself.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, fifo_full, error_route
  );

endinterface

// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - show-ahead per-destination FIFO with registered full flag
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int MAIN_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [MAIN_SIZE-1:0] din,
  input  logic                 pop,
  output logic [MAIN_SIZE-1:0] dout,
  output logic                 valid,
  output logic                 full
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [MAIN_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 full_q, full_d;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop && !empty;
  // Upstream already stalls on full; the guard keeps a stray push from corrupting the head.
  assign do_push = push && !full_q;

  // Next pointers and the full flag they imply, so full is a plain register.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Pointer and flag state; in-flight words are dropped by clearing the pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are left as-is across reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign valid = !empty;
  assign full  = full_q;
  // Mask stale memory so consumers see zero whenever nothing is queued.
  assign dout  = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: rtl/pcie_dispatch_n.sv
// rtl/pcie_dispatch_n.sv - route-decoded N-port dispatcher; DISPATCH_STATS_EN adds per-port packet counters
module pcie_dispatch_n
  import dispatch_pkg::*;
#(
  parameter int DATA_SIZE  = 10,
  parameter int MAIN_SIZE  = 8,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  pcie_dispatch_n_if.slave             bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_PORTS*STATS_W-1:0] pkt_count
`endif
);

  localparam int RW = DATA_SIZE - MAIN_SIZE;

  logic [RW-1:0]                  dest;
  logic                           legal;
  logic                           sel_full;
  logic                           accept;
  logic [NUM_PORTS-1:0]           push_vec;
  logic [NUM_PORTS-1:0]           full_w;
  logic [NUM_PORTS-1:0]           valid_w;
  logic [NUM_PORTS*MAIN_SIZE-1:0] data_w;
  logic                           err_q, err_d;

  assign dest   = RW'(route_of(32'(bus.in_data), MAIN_SIZE));
  assign legal  = (32'(dest) < 32'(NUM_PORTS));
  // Illegal routes are always taken so they can be dropped and flagged.
  assign bus.in_ready = !legal || !sel_full;
  assign accept = bus.in_valid && bus.in_ready;

  // Full flag of the addressed port and the one-hot push; a loop avoids indexing past NUM_PORTS.
  always_comb begin
    sel_full = 1'b0;
    push_vec = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (32'(dest) == 32'(p)) begin
        sel_full    = full_w[p];
        push_vec[p] = accept && legal;
      end
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      dispatch_fifo #(
        .MAIN_SIZE  (MAIN_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_vec[gp]),
        .din   (bus.in_data[MAIN_SIZE-1:0]),
        .pop   (bus.out_ready[gp]),
        .dout  (data_w[gp*MAIN_SIZE +: MAIN_SIZE]),
        .valid (valid_w[gp]),
        .full  (full_w[gp])
      );
    end
  endgenerate

  assign bus.out_data  = data_w;
  assign bus.out_valid = valid_w;
  assign bus.fifo_full = full_w;

  assign err_d = accept && !legal;

  // One-cycle error pulse per dropped word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.error_route = err_q;

`ifdef DISPATCH_STATS_EN
  logic [STATS_W-1:0] cnt_q [NUM_PORTS];
  logic [STATS_W-1:0] cnt_d [NUM_PORTS];

  // Count legal accepts per port; the counter wraps naturally at 16 bits.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p] + STATS_W'(push_vec[p]);
    end
  end

  // Counters are cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
      assign pkt_count[gc*STATS_W +: STATS_W] = cnt_q[gc];
    end
  endgenerate
`endif

endmodule

// File: doc/pcie_dispatch_n.md
# pcie_dispatch_n

Parametrised N-port dispatcher for the adaptive PCIe switching path. Each input word is routed by its header field into a per-destination FIFO, and each destination drains through its own valid/ready handshake. Input backpressure is applied per destination, and out-of-range routes are flagged. It succeeds the fixed two-output Device1 demux and sits between the serial-to-parallel front end and the per-lane egress logic.

## Interface
- DATA_SIZE, 10, total input word width.
- MAIN_SIZE, 8, payload width. The route field is bits [DATA_SIZE-1:MAIN_SIZE], with RW = DATA_SIZE-MAIN_SIZE.
- NUM_PORTS, 4, number of destinations. Legal range is 2..2^RW.
- FIFO_DEPTH, 4, entries per destination FIFO. Must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_SIZE  {route, payload}.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  dispatcher accepts the word this cycle.
- out_data  out  NUM_PORTS*MAIN_SIZE  flattened payloads; port p occupies [p*MAIN_SIZE +: MAIN_SIZE].
- out_valid  out  NUM_PORTS  head of FIFO p is valid.
- out_ready  in  NUM_PORTS  consumer p takes its head word.
- fifo_full  out  NUM_PORTS  FIFO p is full (registered).
- error_route  out  1  one-cycle pulse: a word with route >= NUM_PORTS was accepted.
- pkt_count  out  NUM_PORTS*16  present only with DISPATCH_STATS_EN; described under Configuration.

## Operation
- Decode: dest = in_data[DATA_SIZE-1:MAIN_SIZE].
  - A route is legal when dest < NUM_PORTS.
- in_ready (combinational) is 1 when the route is illegal or fifo_full[dest] == 0.
  - in_ready does not depend on out_ready in the same cycle. There is no full-FIFO bypass.
- Accept occurs when in_valid && in_ready.
  - Legal route: the payload is written to FIFO dest.
  - Illegal route: the word is consumed and dropped, and error_route pulses on the next cycle.
- Each FIFO is show-ahead:
  - out_data slice p = mem[rd_ptr] while out_valid[p] = 1.
  - Pop when out_valid[p] && out_ready[p].
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
- Simultaneous push and pop on the same non-empty, non-full FIFO: both occur and occupancy is unchanged.
- Push to an empty FIFO: the word becomes visible on the next cycle.
- out_ready asserted while out_valid is 0: ignored.
- in_valid = 0: no state change and no error.

## Timing
- Reset asserted (reset = 0), asynchronously:
  - Outputs: out_valid = 0, out_data = 0, fifo_full = 0, error_route = 0, pkt_count = 0.
  - Internal: all pointers = 0.
  - Any in-flight words are discarded.
- Memory contents are not reset. out_data is masked to 0 while out_valid = 0.
- Latency from accept to out_valid is 1 clk. Throughput is 1 word/clk in and 1 word/clk per port out.
- fifo_full updates 1 clk after the push that fills the FIFO, and deasserts 1 clk after a pop from a full FIFO.
- error_route is high for exactly 1 clk per offending word. Back-to-back illegal words give back-to-back pulses.

## Configuration
- DISPATCH_STATS_EN defined:
  - The pkt_count port exists.
  - Each 16-bit counter increments on every legal accept to its port and wraps 0xFFFF -> 0x0000.
  - Counters are cleared by reset only.
- DISPATCH_STATS_EN undefined: the port and counters are absent. Datapath behaviour is identical.

## Structure
- Package dispatch_pkg holds:
  - the clog2 function;
  - the route-field extraction function;
  - the STATS_W = 16 constant.
- Sub-module dispatch_fifo (parameters MAIN_SIZE, FIFO_DEPTH; ports clk, reset, push, din, pop, dout, valid, full) is instantiated NUM_PORTS times in a generate loop.
- The top level holds the decode, in_ready mux, error pulse register and optional counters.

## Test plan
- Reset mid-stream: push 10'h0FF, 10'h0EE to port 0, then pull reset low for 1 clk -> out_valid = 0, out_data = 0, fifo_full = 0 immediately; after release, the next push 10'h0BB is the first output on port 0.
- Routing: send 10'h0FF, 10'h1AA, 10'h2CC, 10'h3DD with all out_ready = 1 -> payloads FF, AA, CC, DD appear on ports 0, 1, 2, 3 respectively, each 1 clk after accept.
- Backpressure: out_ready[1] = 0, send 5x 10'h155 -> first 4 accepted; fifo_full[1] = 1; in_ready = 0 for the 5th; 10'h077 to port 0 is still accepted. Raising out_ready[1] drains 55 x4, then accepts the 5th.
- Illegal route, NUM_PORTS = 3: send 10'h399 -> in_ready = 1, error_route pulses 1 clk, no out_valid rises. A following 10'h011 reaches port 0.
- Simultaneous push and pop on a full port 2 with out_ready[2] = 1 -> the pop occurs, the push is stalled 1 clk, FIFO order is preserved, and no word is lost.
- Stats with DISPATCH_STATS_EN: 65537 legal words to port 3 -> pkt_count slice 3 = 1, other slices 0. Illegal words do not count.
